// File: rtl/traffic_light_controller.sv
// Main/side street traffic light sequencer with a pedestrian walk phase
// and a single side-green extension driven by the side-street vehicle sensor.
module traffic_light_controller #(
  parameter int CLK_DIV = 50000000,
  parameter int TW      = 4,
  parameter int T_BASE  = 6,
  parameter int T_EXT   = 3,
  parameter int T_YEL   = 2
) (
  input  logic       clk,
  input  logic       Reset_asincronico,
  input  logic       Reset_sincronico,
  input  logic       Sensor,
  input  logic       WR_valor,
  output logic       WR_Reset,
  output logic [2:0] Luz_principal,
  output logic [2:0] Luz_secundaria,
  output logic       Luz_peaton,
  output logic [2:0] Estado
);

  localparam int PW = $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);
  localparam logic [TW-1:0] D_BASE    = TW'(T_BASE);
  localparam logic [TW-1:0] D_EXT     = TW'(T_EXT);
  localparam logic [TW-1:0] D_YEL     = TW'(T_YEL);

  typedef enum logic [2:0] {
    S_MG   = 3'd0,
    S_MY   = 3'd1,
    S_WALK = 3'd2,
    S_SG   = 3'd3,
    S_SY   = 3'd4
  } state_t;

  state_t        state;
  state_t        nxt_state;
  logic [PW-1:0] presc;
  logic [TW-1:0] cnt;
  logic [TW-1:0] nxt_cnt;
  logic          ext_flag;
  logic          nxt_flag;
  logic          reload;
  logic          tick;
  logic          expire;

  function automatic logic [2:0] main_lamps(input state_t s);
    case (s)
      S_MG:    return 3'b001;
      S_MY:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  function automatic logic [2:0] side_lamps(input state_t s);
    case (s)
      S_SG:    return 3'b001;
      S_SY:    return 3'b010;
      default: return 3'b100;
    endcase
  endfunction

  assign tick   = (presc == PRESC_MAX);
  assign expire = tick && (cnt == TW'(1));
  assign Estado = state;

  // Next phase and its duration; reload also covers the in-place side-green extension.
  always_comb begin
    reload    = 1'b0;
    nxt_state = state;
    nxt_cnt   = cnt;
    nxt_flag  = 1'b0;
    case (state)
      S_MG: if (expire) begin
        reload    = 1'b1;
        nxt_state = S_MY;
        nxt_cnt   = D_YEL;
      end
      S_MY: if (expire) begin
        reload    = 1'b1;
        nxt_state = WR_valor ? S_WALK : S_SG;
        nxt_cnt   = WR_valor ? D_EXT : D_BASE;
      end
      S_WALK: if (expire) begin
        reload    = 1'b1;
        nxt_state = S_SG;
        nxt_cnt   = D_BASE;
      end
      S_SG: if (expire) begin
        reload = 1'b1;
        if (Sensor && !ext_flag) begin
          nxt_state = S_SG;
          nxt_cnt   = D_EXT;
          nxt_flag  = 1'b1;
        end else begin
          nxt_state = S_SY;
          nxt_cnt   = D_YEL;
        end
      end
      S_SY: if (expire) begin
        reload    = 1'b1;
        nxt_state = S_MG;
        nxt_cnt   = D_BASE;
      end
      default: begin
        reload    = 1'b1;
        nxt_state = S_MG;
        nxt_cnt   = D_BASE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge Reset_asincronico) begin
    if (Reset_asincronico) begin
      state          <= S_MG;
      presc          <= '0;
      cnt            <= D_BASE;
      ext_flag       <= 1'b0;
      WR_Reset       <= 1'b0;
      Luz_principal  <= 3'b001;
      Luz_secundaria <= 3'b100;
      Luz_peaton     <= 1'b0;
    end else if (Reset_sincronico) begin
      state          <= S_MG;
      presc          <= '0;
      cnt            <= D_BASE;
      ext_flag       <= 1'b0;
      WR_Reset       <= 1'b0;
      Luz_principal  <= 3'b001;
      Luz_secundaria <= 3'b100;
      Luz_peaton     <= 1'b0;
    end else if (reload) begin
      state          <= nxt_state;
      presc          <= '0;
      cnt            <= nxt_cnt;
      ext_flag       <= nxt_flag;
      // Walk is only entered from main-yellow, so this fires on its first cycle only.
      WR_Reset       <= (nxt_state == S_WALK) && (state != S_WALK);
      Luz_principal  <= main_lamps(nxt_state);
      Luz_secundaria <= side_lamps(nxt_state);
      Luz_peaton     <= (nxt_state == S_WALK);
    end else begin
      WR_Reset <= 1'b0;
      if (tick) begin
        presc <= '0;
        cnt   <= cnt - TW'(1);
      end else begin
        presc <= presc + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Scoreboard bench: expected phase segments are queued by stimulus and
// compared by a monitor each time Estado changes.
module tb_traffic_light_controller;

  logic       clk = 1'b0;
  logic       Reset_asincronico;
  logic       Reset_sincronico;
  logic       Sensor;
  logic       WR_valor;
  logic       WR_Reset;
  logic [2:0] Luz_principal;
  logic [2:0] Luz_secundaria;
  logic       Luz_peaton;
  logic [2:0] Estado;

  always #5 clk = ~clk;

  traffic_light_controller #(
    .CLK_DIV(4), .TW(4), .T_BASE(3), .T_EXT(2), .T_YEL(1)
  ) dut (
    .clk              (clk),
    .Reset_asincronico(Reset_asincronico),
    .Reset_sincronico (Reset_sincronico),
    .Sensor           (Sensor),
    .WR_valor         (WR_valor),
    .WR_Reset         (WR_Reset),
    .Luz_principal    (Luz_principal),
    .Luz_secundaria   (Luz_secundaria),
    .Luz_peaton       (Luz_peaton),
    .Estado           (Estado)
  );

  typedef struct {
    logic [2:0] st;
    int         len;
    int         pulses;
  } seg_t;

  seg_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  // Monitor segment tracking
  bit         cur_valid = 0;
  bit         abort_seg = 0;
  logic [2:0] cur_st;
  int         cur_len;
  int         cur_wr;
  bit         cur_wr_first;

  task automatic push(input logic [2:0] st, input int len, input int pulses);
    seg_t s;
    s.st = st; s.len = len; s.pulses = pulses;
    exp_q.push_back(s);
  endtask

  // One full round: MG 12, MY 4, optional WALK 8 with one clear pulse, SG, SY 4.
  task automatic push_round(input bit walk, input int sg_len);
    push(3'd0, 12, 0);
    push(3'd1, 4, 0);
    if (walk) push(3'd2, 8, 1);
    push(3'd3, sg_len, 0);
    push(3'd4, 4, 0);
  endtask

  task automatic close_seg();
    seg_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL seg_unexpected: got state=%0d len=%0d pulses=%0d, required no segment",
               cur_st, cur_len, cur_wr);
    end else begin
      e = exp_q.pop_front();
      if (e.st != cur_st || e.len != cur_len || e.pulses != cur_wr ||
          (e.pulses > 0 && !cur_wr_first)) begin
        failures++;
        $display("FAIL segment: got state=%0d len=%0d pulses=%0d first=%0d, required state=%0d len=%0d pulses=%0d",
                 cur_st, cur_len, cur_wr, cur_wr_first, e.st, e.len, e.pulses);
      end
    end
  endtask

  task automatic check_lamps();
    logic [2:0] em, es;
    logic       ep;
    bit         legal;
    legal = 1;
    em = 3'b100; es = 3'b100; ep = 1'b0;
    case (Estado)
      3'd0: em = 3'b001;
      3'd1: em = 3'b010;
      3'd2: ep = 1'b1;
      3'd3: es = 3'b001;
      3'd4: es = 3'b010;
      default: legal = 0;
    endcase
    checks++;
    if (!legal || Luz_principal != em || Luz_secundaria != es || Luz_peaton != ep) begin
      failures++;
      $display("FAIL lamps: state=%0d got main=%b side=%b walk=%b, required main=%b side=%b walk=%b",
               Estado, Luz_principal, Luz_secundaria, Luz_peaton, em, es, ep);
    end
  endtask

  always @(negedge clk) begin
    if (Reset_asincronico) begin
      cur_valid = 0;
      abort_seg = 0;
      checks++;
      if (Estado != 3'd0 || Luz_principal != 3'b001 || Luz_secundaria != 3'b100 ||
          Luz_peaton != 1'b0 || WR_Reset != 1'b0) begin
        failures++;
        $display("FAIL reset_vals: got st=%0d main=%b side=%b walk=%b wr=%b, required st=0 main=001 side=100 walk=0 wr=0",
                 Estado, Luz_principal, Luz_secundaria, Luz_peaton, WR_Reset);
      end
    end else begin
      check_lamps();
      if (cur_valid && !abort_seg && Estado == cur_st) begin
        cur_len++;
        if (WR_Reset) cur_wr++;
      end else begin
        if (cur_valid && !abort_seg) close_seg();
        cur_valid    = 1;
        cur_st       = Estado;
        cur_len      = 1;
        cur_wr       = WR_Reset ? 1 : 0;
        cur_wr_first = WR_Reset;
      end
      abort_seg = Reset_sincronico;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    Reset_asincronico = 1'b1;
    Reset_sincronico  = 1'b0;
    Sensor            = 1'b0;
    WR_valor          = 1'b0;
    repeat (2) @(posedge clk);
    #1 Reset_asincronico = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset_asincronico = 1'b1;
    Reset_sincronico  = 1'b0;
    Sensor            = 1'b0;
    WR_valor          = 1'b0;

    // Free run: period 32, no walk
    do_reset();
    push_round(0, 12);
    push_round(0, 12);
    repeat (70) @(posedge clk);

    // Walk request held from cycle 5: every round walks, period 40
    do_reset();
    push_round(1, 12);
    push_round(1, 12);
    for (int c = 1; c <= 85; c++) begin
      @(posedge clk); #1;
      if (c == 5) WR_valor = 1'b1;
    end

    // Sensor held: side green 12 + 8, only one extension
    do_reset();
    Sensor = 1'b1;
    push_round(0, 20);
    push_round(0, 20);
    repeat (85) @(posedge clk);

    // Request rises during side green: served one round later, cleared by pulse
    do_reset();
    push_round(0, 12);
    push_round(1, 12);
    push_round(0, 12);
    for (int c = 1; c <= 110; c++) begin
      @(posedge clk); #1;
      if (c == 20) WR_valor = 1'b1;
      if (WR_Reset) WR_valor = 1'b0;
    end

    // Async reset between edges in the middle of walk
    do_reset();
    WR_valor = 1'b1;
    push(3'd0, 12, 0);
    push(3'd1, 4, 0);
    repeat (19) @(posedge clk);
    #3;
    Reset_asincronico = 1'b1;
    WR_valor          = 1'b0;
    @(posedge clk); #1;
    Reset_asincronico = 1'b0;
    push_round(0, 12);
    repeat (40) @(posedge clk);

    // Sync reset on the side-green expiry edge wins over the move to side yellow
    do_reset();
    push(3'd0, 12, 0);
    push(3'd1, 4, 0);
    push_round(0, 12);
    for (int c = 1; c <= 65; c++) begin
      @(posedge clk); #1;
      Reset_sincronico = (c == 27);
    end

    do_reset();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL leftover: got %0d unmatched segments, required 0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
